// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - round-robin two-lane arbiter with burst length and registered output stage
// Optional per-lane grant counters: define MUX_ARBITER_STATS_EN.
module mux_arbiter #(
    parameter int WIDTH = 4,
    parameter int BURST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_0,
    input  logic [WIDTH-1:0] data_0,
    output logic             ready_0,
    input  logic             valid_1,
    input  logic [WIDTH-1:0] data_1,
    output logic             ready_1,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    input  logic             ready_out,
    output logic             lane_out
`ifdef MUX_ARBITER_STATS_EN
    ,
    output logic [7:0]       grant_cnt_0,
    output logic [7:0]       grant_cnt_1
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [4:0] BURST_V = 5'(BURST);

    state_t     state;
    logic       ptr;
    logic [3:0] cnt;
    logic       grant_0;
    logic       grant_1;
    logic       can_load;
    logic       xfer;
    logic       g;
    logic [4:0] cnt_inc;

    // Preferred lane wins when valid; otherwise the other lane takes the slot.
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (!ptr) begin
            if (valid_0)      grant_0 = 1'b1;
            else if (valid_1) grant_1 = 1'b1;
        end else begin
            if (valid_1)      grant_1 = 1'b1;
            else if (valid_0) grant_0 = 1'b1;
        end
    end

    assign can_load  = (state == EMPTY) || ready_out;
    assign ready_0   = can_load & grant_0 & ~reset;
    assign ready_1   = can_load & grant_1 & ~reset;
    assign xfer      = ready_0 | ready_1;
    assign g         = ready_1;
    assign cnt_inc   = {1'b0, cnt} + 5'd1;
    assign valid_out = (state == FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            data_out <= '0;
            lane_out <= 1'b0;
            ptr      <= 1'b0;
            cnt      <= 4'd0;
        end else if (xfer) begin
            state    <= FULL;
            data_out <= g ? data_1 : data_0;
            lane_out <= g;
            if (g == ptr) begin
                if (cnt_inc == BURST_V) begin
                    ptr <= ~ptr;
                    cnt <= 4'd0;
                end else begin
                    cnt <= cnt_inc[3:0];
                end
            end else begin
                cnt <= 4'd0;
            end
        end else if (state == FULL && ready_out) begin
            state <= EMPTY;
        end
    end

`ifdef MUX_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt_0 <= 8'd0;
            grant_cnt_1 <= 8'd0;
        end else begin
            if (ready_0) grant_cnt_0 <= grant_cnt_0 + 8'd1;
            if (ready_1) grant_cnt_1 <= grant_cnt_1 + 8'd1;
        end
    end
`endif

endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Two-requester scheduler in front of the 4-bit 2:1 mux datapath.
- Each source (lane 0 / lane 1) presents data with a valid/ready handshake.
- Arbitration is round-robin with a configurable burst length. The winner's word is captured into a single registered output stage, which honours downstream backpressure.
- Replaces the free-running selector toggle with demand-driven, fair sharing of the output.

Parameters:
- WIDTH, 4, data width of each lane and of the output.
- BURST, 1, maximum consecutive grants to the preferred lane while the other lane is waiting; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high (asserted = 1, sampled on posedge clk only).
- valid_0  input  1  lane 0 has data.
- data_0  input  WIDTH  lane 0 data.
- ready_0  output  1  lane 0 word accepted this cycle.
- valid_1  input  1  lane 1 has data.
- data_1  input  WIDTH  lane 1 data.
- ready_1  output  1  lane 1 word accepted this cycle.
- data_out  output  WIDTH  registered output word.
- valid_out  output  1  data_out holds a word.
- ready_out  input  1  downstream consumes data_out.
- lane_out  output  1  source lane of the current data_out.

Behaviour:
- Reset (synchronous, any cycle, overrides all activity):
  - Clears to 0: data_out, valid_out, lane_out, ptr (preferred lane), cnt (4-bit burst counter).
  - An in-flight word is dropped.
  - ready_0 = ready_1 = 0 while reset is high.
- State machine, two states:
  - EMPTY (valid_out = 0) and FULL (valid_out = 1).
  - can_load = EMPTY | (FULL & ready_out).
- Grant (combinational from ptr, valid_0, valid_1):
  - If valid[ptr] = 1, grant ptr.
  - Else if valid[~ptr] = 1, grant ~ptr.
  - Else no grant.
- Handshake outputs:
  - ready_i = can_load & grant_i & ~reset; at most one ready high per cycle.
  - Transfer on lane i occurs when valid_i & ready_i.
  - ready_i never depends on data.
- On a transfer from lane g:
  - data_out <= data_g, lane_out <= g, valid_out <= 1.
  - Next state is FULL.
- Latency: one cycle from transfer to data_out valid.
- Throughput: one word per cycle when ready_out stays 1 (FULL -> FULL, pass-through).
- FULL & ready_out & no grant: valid_out <= 0, next state EMPTY.
- FULL & ~ready_out (stall): data_out, lane_out and valid_out hold; no transfer; ptr and cnt hold.
- Burst / round-robin update, only on a transfer from g:
  - g == ptr and cnt + 1 == BURST: ptr <= ~ptr, cnt <= 0.
  - g == ptr otherwise: cnt <= cnt + 1.
  - g != ptr (preferred lane idle): ptr unchanged, cnt <= 0.
- With BURST = 1 and both lanes continuously valid, grants strictly alternate 0,1,0,1 starting with lane 0 after reset.
- Only one valid lane: it is served every loadable cycle regardless of ptr; there are no idle bubbles.
- Source rules (bench checks): a source holding valid may not drop it or change data until ready.
- Starvation bound: a continuously valid lane waits at most BURST transfers.

Optional Feature:
- Macro: MUX_ARBITER_STATS_EN.
- When defined, the block adds outputs grant_cnt_0 and grant_cnt_1 (8 bits each).
  - Each increments by 1 on every transfer from its lane.
  - Each wraps 255 -> 0.
  - Each clears on reset.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-stream: while FULL with data_out = 4'hA, assert reset for 1 cycle -> next cycle valid_out = 0, data_out = 0, lane_out = 0, ready_0 = ready_1 = 0 during reset; first grant after reset goes to lane 0.
- Alternation: BURST = 1, both valid, data_0 = 4'h3, data_1 = 4'hC, ready_out = 1 -> data_out sequence 3, C, 3, C with lane_out 0, 1, 0, 1, one word per cycle.
- Burst: BURST = 3, both valid, ready_out = 1 -> lane_out sequence 0, 0, 0, 1, 1, 1, 0.
- Backpressure: FULL with data_out = 4'h5, ready_out = 0 for 4 cycles, valid_1 = 1 -> data_out stays 5 and ready_1 = 0 for all 4 cycles; ready_out = 1 -> ready_1 = 1, lane 1 word appears next cycle.
- Single requester: only valid_1 = 1 with data 1, 2, 3, ready_out = 1 -> ready_1 = 1 every cycle, data_out 1, 2, 3 on consecutive cycles, cnt stays 0 and ptr stays 0.
- Drain: last transfer, then valid_0 = valid_1 = 0 with ready_out = 1 -> valid_out falls to 0 one cycle later. With MUX_ARBITER_STATS_EN, after 256 lane-0 transfers grant_cnt_0 = 0.
